// File: rtl/result_reg_pkg.sv
// Shared types and sizing for the result register file controller.
package result_reg_pkg;
  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int CNT_W    = IDX_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DRAIN = 2'd2} rr_state_t;
  typedef logic [IDX_W-1:0]  rr_idx_t;
  typedef logic [DATA_W-1:0] rr_word_t;
  typedef logic [CNT_W-1:0]  rr_cnt_t;

  localparam rr_cnt_t MAX_CNT = rr_cnt_t'(NUM_REGS);

  // Requests beyond the file size drain the whole file.
  function automatic rr_cnt_t sat_count(input rr_cnt_t raw);
    return (raw > MAX_CNT) ? MAX_CNT : raw;
  endfunction
endpackage

// File: rtl/result_reg_ctrl_if.sv
// Write requesters, command pulses, drain stream and register-file port of the controller.
interface result_reg_ctrl_if;
  import result_reg_pkg::*;

  logic     wr_req_a;
  rr_idx_t  wr_idx_a;
  rr_word_t wr_data_a;
  logic     wr_ack_a;
  logic     wr_req_b;
  rr_idx_t  wr_idx_b;
  rr_word_t wr_data_b;
  logic     wr_ack_b;
  logic     clear_req;
  logic     drain_start;
  rr_cnt_t  drain_count;
  logic     out_valid;
  logic     out_ready;
  rr_word_t out_word;
  logic     out_last;
  logic     busy;
  rr_idx_t  rf_in_sel;
  logic     rf_w_enable;
  logic     rf_clear_data;
  rr_word_t rf_in_data;
  rr_idx_t  rf_out_sel;
  rr_word_t rf_out_data;

  modport master (
    output wr_req_a, wr_idx_a, wr_data_a, wr_req_b, wr_idx_b, wr_data_b,
    output clear_req, drain_start, drain_count, out_ready, rf_out_data,
    input  wr_ack_a, wr_ack_b, out_valid, out_word, out_last, busy,
    input  rf_in_sel, rf_w_enable, rf_clear_data, rf_in_data, rf_out_sel
  );

  modport slave (
    input  wr_req_a, wr_idx_a, wr_data_a, wr_req_b, wr_idx_b, wr_data_b,
    input  clear_req, drain_start, drain_count, out_ready, rf_out_data,
    output wr_ack_a, wr_ack_b, out_valid, out_word, out_last, busy,
    output rf_in_sel, rf_w_enable, rf_clear_data, rf_in_data, rf_out_sel
  );
endinterface

// File: rtl/result_registers.sv
// 16x16 result register file: one write port, whole-file clear, combinational read.
module result_registers
  import result_reg_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  rr_idx_t  in_sel,
  input  logic     w_enable,
  input  logic     clear_data,
  input  rr_word_t in_data,
  input  rr_idx_t  out_sel,
  output rr_word_t out_data
);
  rr_word_t regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst || clear_data) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (w_enable) begin
      regs[in_sel] <= in_data;
    end
  end

  assign out_data = regs[out_sel];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last_q;  // 0: A granted last, 1: B granted last

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (|grant)
      last_q <= grant[1];
  end
endmodule

// File: rtl/result_reg_ctrl.sv
// Result register file controller: write arbitration, clear sequencing and stream drain.
//   state | meaning
//   IDLE  | arbitrate writes, accept clear/drain commands
//   CLEAR | one-cycle clear strobe to the register file
//   DRAIN | stream registers 0..cnt-1 out over valid/ready
module result_reg_ctrl
  import result_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  result_reg_ctrl_if.slave   bus
);
  rr_state_t state_q, state_d;
  rr_cnt_t   ptr_q, ptr_d;
  rr_cnt_t   cnt_q, cnt_d;
  logic      clr_pend_q, clr_pend_d;
  logic      out_valid_q, out_valid_d;
  logic      out_last_q, out_last_d;
  rr_word_t  out_word_q, out_word_d;

  rr_cnt_t   eff_cnt;
  logic      drain_go;
  logic      arb_en;
  logic [1:0] grant;
  logic      load;
  logic      accept;

  assign eff_cnt  = sat_count(bus.drain_count);
  assign drain_go = bus.drain_start && (eff_cnt != '0);
  // Clear and drain commands pre-empt writes in the same cycle.
  assign arb_en   = (state_q == IDLE) && !bus.clear_req && !drain_go && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   ({bus.wr_req_b, bus.wr_req_a}),
    .grant (grant)
  );

  assign load   = (state_q == DRAIN) && (!out_valid_q || bus.out_ready) && (ptr_q < cnt_q);
  assign accept = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    clr_pend_d  = clr_pend_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_word_d  = out_word_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
        end else if (drain_go) begin
          state_d = DRAIN;
          cnt_d   = eff_cnt;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (bus.clear_req)
          clr_pend_d = 1'b1;
        if (load) begin
          out_word_d  = bus.rf_out_data;
          out_valid_d = 1'b1;
          out_last_d  = (ptr_q == cnt_q - 1'b1);
          ptr_d       = ptr_q + 1'b1;
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (accept && out_last_q) begin
          state_d    = (clr_pend_q || bus.clear_req) ? CLEAR : IDLE;
          clr_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      clr_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      clr_pend_q  <= clr_pend_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_word_q  <= out_word_d;
    end
  end

  assign bus.wr_ack_a      = grant[0];
  assign bus.wr_ack_b      = grant[1];
  assign bus.rf_w_enable   = |grant;
  assign bus.rf_in_sel     = grant[0] ? bus.wr_idx_a  : (grant[1] ? bus.wr_idx_b  : '0);
  assign bus.rf_in_data    = grant[0] ? bus.wr_data_a : (grant[1] ? bus.wr_data_b : '0);
  assign bus.rf_clear_data = (state_q == CLEAR);
  assign bus.rf_out_sel    = ptr_q[IDX_W-1:0];
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_word      = out_word_q;
  assign bus.busy          = (state_q != IDLE) || clr_pend_q;
endmodule

// File: tb/tb_result_reg_ctrl.sv
// Directed bench for result_reg_ctrl driving a result_registers instance.
module tb_result_reg_ctrl;
  import result_reg_pkg::*;

  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  int   n_chk  = 0;
  int   n_bad  = 0;
  logic [15:0] mem_model [16];

  result_reg_ctrl_if bus();

  result_reg_ctrl u_dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  result_registers u_rf (
    .clk        (tb_clk),
    .rst        (rst),
    .in_sel     (bus.rf_in_sel),
    .w_enable   (bus.rf_w_enable),
    .clear_data (bus.rf_clear_data),
    .in_data    (bus.rf_in_data),
    .out_sel    (bus.rf_out_sel),
    .out_data   (bus.rf_out_data)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_model[i] = 16'h0;
  endtask

  task automatic write_one(input bit is_b, input logic [3:0] idx, input logic [15:0] data);
    if (is_b) begin
      bus.wr_req_b = 1'b1; bus.wr_idx_b = idx; bus.wr_data_b = data;
    end else begin
      bus.wr_req_a = 1'b1; bus.wr_idx_a = idx; bus.wr_data_a = data;
    end
    #1;
    check("wr_ack_a", 32'(bus.wr_ack_a), 32'(!is_b));
    check("wr_ack_b", 32'(bus.wr_ack_b), 32'(is_b));
    check("rf_w_enable", 32'(bus.rf_w_enable), 32'd1);
    check("rf_in_sel", 32'(bus.rf_in_sel), 32'(idx));
    check("rf_in_data", 32'(bus.rf_in_data), 32'(data));
    mem_model[idx] = data;
    tick();
    bus.wr_req_a = 1'b0;
    bus.wr_req_b = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
  // clr_at >= 0 pulses clear_req right after that many words were accepted.
  task automatic do_drain(input int cnt_in, input int n_exp, input int mode,
                          input int clr_at, input bit busy_after);
    logic [15:0] got_w [$];
    bit          got_l [$];
    logic [15:0] prev_w;
    bit          prev_l;
    bit          held;
    bit          rdy;
    int          k;
    held = 1'b0; prev_w = '0; prev_l = 1'b0; k = 0;
    bus.drain_start = 1'b1;
    bus.drain_count = 5'(cnt_in);
    #1;
    if (bus.wr_req_a) check("ack_stall_start", 32'(bus.wr_ack_a), 32'd0);
    tick();
    bus.drain_start = 1'b0;
    check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    check("busy_in_drain", 32'(bus.busy), 32'd1);
    tick();
    check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
    while (got_w.size() < n_exp && k < 300) begin
      bus.clear_req = 1'b0;
      rdy = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      bus.out_ready = rdy;
      #1;
      if (bus.wr_req_a) check("ack_stall", 32'(bus.wr_ack_a), 32'd0);
      if (bus.out_valid) begin
        if (held) begin
          check("hold_word", 32'(bus.out_word), 32'(prev_w));
          check("hold_last", 32'(bus.out_last), 32'(prev_l));
        end
        if (rdy) begin
          got_w.push_back(bus.out_word);
          got_l.push_back(bus.out_last);
          held = 1'b0;
          if (got_w.size() == clr_at) bus.clear_req = 1'b1;
        end else begin
          held = 1'b1; prev_w = bus.out_word; prev_l = bus.out_last;
        end
      end
      k++;
      tick();
    end
    bus.clear_req = 1'b0;
    bus.out_ready = 1'b0;
    check("drain_words_seen", 32'(got_w.size()), 32'(n_exp));
    if (mode == 0) check("throughput_cycles", 32'(k), 32'(n_exp));
    check("valid_drops", 32'(bus.out_valid), 32'd0);
    check("last_drops", 32'(bus.out_last), 32'd0);
    check("busy_after", 32'(bus.busy), 32'(busy_after));
    for (int i = 0; i < got_w.size(); i++) begin
      check($sformatf("word[%0d]", i), 32'(got_w[i]), 32'(mem_model[i]));
      check($sformatf("last[%0d]", i), 32'(got_l[i]), 32'(i == n_exp - 1));
    end
  endtask

  initial begin
    int seen;
    int guard;
    int bad_cycles;
    bus.wr_req_a = 0; bus.wr_idx_a = '0; bus.wr_data_a = '0;
    bus.wr_req_b = 0; bus.wr_idx_b = '0; bus.wr_data_b = '0;
    bus.clear_req = 0; bus.drain_start = 0; bus.drain_count = '0; bus.out_ready = 0;
    model_clear();

    // 1. reset, single writes, drain 8
    repeat (3) tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_word", 32'(bus.out_word), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_clear", 32'(bus.rf_clear_data), 32'd0);
    check("rst_wen", 32'(bus.rf_w_enable), 32'd0);
    check("rst_out_sel", 32'(bus.rf_out_sel), 32'd0);
    rst = 1'b0;
    tick();
    write_one(1'b0, 4'd3, 16'hBEEF);
    write_one(1'b1, 4'd7, 16'h1234);
    do_drain(8, 8, 0, -1, 1'b0);

    // 2. tie between A and B: A wins first since B was granted last
    bus.wr_req_a = 1; bus.wr_idx_a = 4'd1; bus.wr_data_a = 16'hA001;
    bus.wr_req_b = 1; bus.wr_idx_b = 4'd2; bus.wr_data_b = 16'hB002;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("tie_ack_a", 32'(bus.wr_ack_a), 32'((c % 2) == 0));
      check("tie_ack_b", 32'(bus.wr_ack_b), 32'((c % 2) == 1));
      check("tie_in_data", 32'(bus.rf_in_data), ((c % 2) == 0) ? 32'hA001 : 32'hB002);
      tick();
    end
    bus.wr_req_a = 0; bus.wr_req_b = 0;
    mem_model[1] = 16'hA001;
    mem_model[2] = 16'hB002;

    // 3. drain 16 with stalls
    do_drain(16, 16, 1, -1, 1'b0);

    // clear and drain in the same IDLE cycle: drain is dropped
    bus.clear_req = 1; bus.drain_start = 1; bus.drain_count = 5'd4;
    tick();
    bus.clear_req = 0; bus.drain_start = 0;
    check("idle_clr_strobe", 32'(bus.rf_clear_data), 32'd1);
    tick();
    check("idle_clr_done", 32'(bus.rf_clear_data), 32'd0);
    check("idle_clr_busy", 32'(bus.busy), 32'd0);
    tick();
    check("drop_drain_valid", 32'(bus.out_valid), 32'd0);
    model_clear();
    write_one(1'b0, 4'd0, 16'h1111);
    write_one(1'b1, 4'd4, 16'h4444);

    // 4. clear mid-drain, then a drain reads zeros
    do_drain(5, 5, 0, 2, 1'b1);
    check("post_drain_clear", 32'(bus.rf_clear_data), 32'd1);
    bus.clear_req = 1;
    tick();
    bus.clear_req = 0;
    check("clear_absorbed", 32'(bus.rf_clear_data), 32'd0);
    check("clear_absorbed_busy", 32'(bus.busy), 32'd0);
    model_clear();
    do_drain(5, 5, 0, -1, 1'b0);

    // 5. A stalls during a drain, lands once IDLE
    write_one(1'b0, 4'd2, 16'h2222);
    bus.wr_req_a = 1; bus.wr_idx_a = 4'd9; bus.wr_data_a = 16'h5A5A;
    do_drain(4, 4, 0, -1, 1'b0);
    #1;
    check("ack_after_drain", 32'(bus.wr_ack_a), 32'd1);
    mem_model[9] = 16'h5A5A;
    tick();
    bus.wr_req_a = 0;
    do_drain(10, 10, 0, -1, 1'b0);

    // 6. reset during word 3 of drain 10
    bus.drain_start = 1; bus.drain_count = 5'd10;
    tick();
    bus.drain_start = 0;
    bus.out_ready = 1;
    seen = 0; guard = 0;
    while (seen < 2 && guard < 50) begin
      if (bus.out_valid) seen++;
      guard++;
      tick();
    end
    check("rst_drain_reach", 32'(seen), 32'd2);
    check("word3_valid", 32'(bus.out_valid), 32'd1);
    check("word3_data", 32'(bus.out_word), 32'(mem_model[2]));
    rst = 1'b1;
    tick();
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    model_clear();
    bad_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid || bus.rf_w_enable || bus.busy) bad_cycles++;
      tick();
    end
    check("abort_quiet", 32'(bad_cycles), 32'd0);
    bus.out_ready = 0;

    // drain_count 0 is a no-op, 20 saturates to 16
    bus.drain_start = 1; bus.drain_count = 5'd0;
    tick();
    bus.drain_start = 0;
    check("cnt0_busy", 32'(bus.busy), 32'd0);
    tick();
    check("cnt0_valid", 32'(bus.out_valid), 32'd0);
    write_one(1'b0, 4'd15, 16'hF00F);
    write_one(1'b1, 4'd0, 16'h0F0F);
    do_drain(20, 16, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
